sync_fifo: RTL and testbench

Single-clock, first-in first-out buffer: FIFO_DEPTH entries of DATA_WIDTH bits, with registered read data, full/empty status flags and an occupancy count. It decouples a producer and a consumer in the same clock domain. Writes and reads are independent single-cycle handshakes, and both may occur in the same cycle.

---
 rtl/sync_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_mem.sv | 40 ++++
 rtl/sync_fifo.sv | 88 ++++++++
 tb/tb_sync_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and pointer helpers for sync_fifo.
// Provides DEF_DATA_WIDTH, DEF_FIFO_DEPTH and ptr_occ().
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 32;

    // Occupancy of a FIFO from its write and read pointers.
    // Pointers are passed zero-extended to 32 bits; the difference
    // is reduced modulo 2^pw so pointer rollover is handled.
    function automatic logic [31:0] ptr_occ(
        input logic [31:0] wptr,
        input logic [31:0] rptr,
        input int unsigned pw
    );
        logic [31:0] diff;
        logic [31:0] mask;
        diff = wptr - rptr;
        mask = (32'd1 << pw) - 32'd1;
        return diff & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO_DEPTH x DATA_WIDTH register array, one write port,
// registered read port. Ports: clk, rst_n (sync, active high), i_we,
// i_waddr, i_wdata, i_re, i_raddr, o_rdata. Only o_rdata is reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-edge write to the read address returns the old entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, full/empty and
// occupancy count. Ports: clk, rst_n (sync, active high), wen, wdata, full,
// ren, rdata, empty, count. Define SYNC_FIFO_ASSERT_EN for sim checks.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] count
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] r_wptr;
    logic [ADDR_WIDTH:0] r_rptr;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [31:0]         w_occ32;
    logic [ADDR_WIDTH:0] w_occ;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                   (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);

    // When full, a read frees the slot the write lands in.
    assign w_wr_acc = wen && (!full || ren);
    assign w_rd_acc = ren && !empty;

    assign w_occ32 = ptr_occ(32'(r_wptr), 32'(r_rptr), PTR_W);
    assign w_occ   = w_occ32[ADDR_WIDTH:0];
    assign count   = w_occ[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_wr_acc),
        .i_waddr(r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata(wdata),
        .i_re   (w_rd_acc),
        .i_raddr(r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata(rdata)
    );

`ifdef SYNC_FIFO_ASSERT_EN
    always @(posedge clk) begin
        if (!rst_n) begin
            if (wen && full && !ren) begin
                $error("sync_fifo: overflow (wen && full && !ren)");
            end
            if (ren && empty) begin
                $error("sync_fifo: underflow (ren && empty)");
            end
            if (w_occ > (ADDR_WIDTH+1)'(FIFO_DEPTH)) begin
                $error("sync_fifo: occupancy exceeds FIFO_DEPTH");
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo
// against a queue-based reference model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          ren;
    logic          full;
    logic          empty;
    logic [DW-1:0] rdata;
    logic [AW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_rdata;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wen  (wen),
        .wdata(wdata),
        .full (full),
        .ren  (ren),
        .rdata(rdata),
        .empty(empty),
        .count(count)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = q.size();
        check({tag, ".count"}, 32'(count), 32'(sz % DEPTH));
        check({tag, ".full"},  32'(full),  32'(sz == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
    endtask

    // One clock with the given request; model updated from the rules.
    task automatic step(input logic w, input logic [DW-1:0] d,
                        input logic r, input string tag);
        bit acc_w;
        bit acc_r;
        wen   = w;
        wdata = d;
        ren   = r;
        acc_w = w && (q.size() < DEPTH || r);
        acc_r = r && (q.size() > 0);
        if (acc_r) exp_rdata = q.pop_front();
        if (acc_w) q.push_back(d);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input int edges);
        rst_n = 1'b1;
        wen   = 1'b1;
        ren   = 1'b1;
        wdata = DW'($urandom);
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        q.delete();
        exp_rdata = '0;
        check_state("reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] first;
        rst_n = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = '0;
        exp_rdata = '0;

        do_reset(2);

        // ordering with overlapping read/write
        step(1, 8'd10, 0, "ord_w");
        step(1, 8'd11, 0, "ord_w");
        step(1, 8'd12, 0, "ord_w");
        check("ord_peak", 32'(count), 32'd3);
        step(1, 8'd13, 1, "ord_rw");
        check("ord_rd10", 32'(rdata), 32'd10);
        check("ord_hold", 32'(count), 32'd3);
        step(1, 8'd14, 1, "ord_rw");
        check("ord_rd11", 32'(rdata), 32'd11);
        for (int i = 12; i <= 14; i++) begin
            step(0, 8'd0, 1, "ord_r");
            check("ord_rd", 32'(rdata), 32'(i));
        end

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, "fill_w");
        check("fill_full", 32'(full), 32'd1);
        check("fill_cnt0", 32'(count), 32'd0);
        step(1, 8'd99, 0, "ovf");
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'd0, 1, "fill_r");
            check("fill_rd", 32'(rdata), 32'(i));
        end
        check("fill_empty", 32'(empty), 32'd1);

        // underflow holds rdata
        step(0, 8'd0, 1, "unf");
        check("unf_hold", 32'(rdata), 32'd31);

        // simultaneous access while full
        for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, "fs_w");
        first = q[0];
        step(1, 8'd77, 1, "fs_rw");
        check("fs_oldest", 32'(rdata), 32'(first));
        check("fs_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(0, 8'd0, 1, "fs_r");
        check("fs_last77", 32'(rdata), 32'd77);

        // simultaneous access while empty
        first = rdata;
        step(1, 8'd5, 1, "es_rw");
        check("es_hold", 32'(rdata), 32'(first));
        check("es_cnt1", 32'(count), 32'd1);

        // reset mid-operation discards contents
        for (int i = 0; i < 7; i++) step(1, DW'($urandom), 0, "mr_w");
        do_reset(1);
        step(0, 8'd0, 1, "mr_unf");

        // randomized traffic in phases of different read/write bias
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            int rp;
            wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 20;
            rp = 100 - wp;
            for (int i = 0; i < 300; i++) begin
                step(($urandom_range(99) < wp), DW'($urandom),
                     ($urandom_range(99) < rp), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
